// File: rtl/bcd_pkg.sv
// Shared definitions for the packed-BCD to binary converter:
// FSM state encoding, BCD digit width and a helper that returns the
// minimum binary width able to hold any DIGITS-digit decimal value.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W = 4;

    // ceil(log2(10^digits)): bits needed for values 0 .. 10^digits-1
    function automatic int bcd_min_bin_w(input int digits);
        logic [63:0] max_p;
        int          w;
        max_p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            max_p = max_p * 64'd10;
        end
        w = 0;
        for (int i = 0; i < 64; i++) begin
            if ((64'd1 << w) < max_p) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Reverse double-dabble digit correction: after a right shift, any
// BCD digit that reads 8 or more had a ten's half shifted into it and
// is brought back into range by subtracting 3 (4-bit, no carry out).
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    assign digit_o = (digit_i >= 4'd8) ? (digit_i - 4'd3) : digit_i;

endmodule

// File: rtl/bcd2binary_reverse_dabble.sv
// Sequential packed-BCD to binary converter (reverse double dabble).
// One right shift of the {bcd, bin} working register per cycle, followed
// by a per-digit subtract-3 correction on the bcd field. Fixed latency of
// BIN_W+1 cycles from the accepting edge to the valid pulse.
//
// Optional feature: define BCD_CHECK_EN to flag input digits above 9.
// With it, such a conversion reports err=1 and out_binary=0; without it
// err is tied low and invalid digits simply run through the arithmetic.
module bcd2binary_reverse_dabble
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] in_bcd,
    output logic                          ready,
    output logic                          valid,
    output logic [BIN_W-1:0]              out_binary,
    output logic                          err
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    // Refuse to build a converter whose output cannot hold 10^DIGITS-1.
    generate
        if (BIN_W < bcd_min_bin_w(DIGITS)) begin : g_bin_w_too_small
            $error("BIN_W is too small for the requested number of BCD digits");
        end
    endgenerate

    state_t             state_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [BIN_W-1:0]   bin_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ready_q;
    logic               valid_q;
    logic [BIN_W-1:0]   out_q;

    logic [BCD_W-1:0]   shifted_bcd;
    logic [BCD_W-1:0]   bcd_d;
    logic [BIN_W-1:0]   bin_d;

    // Right shift of the concatenated register: bcd LSB moves into bin MSB.
    assign shifted_bcd = bcd_q >> 1;
    assign bin_d       = {bcd_q[0], bin_q[BIN_W-1:1]};

    // Independent correction of every digit of the shifted bcd field.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit_adjust u_adjust (
                .digit_i (shifted_bcd[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .digit_o (bcd_d[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

`ifdef BCD_CHECK_EN
    logic               inv_q;
    logic               err_q;
    logic [DIGITS-1:0]  digit_bad;
    logic               in_invalid;

    // One flag per input digit: set when the digit is outside 0..9.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_check
            assign digit_bad[gi] = (in_bcd[gi*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'd9);
        end
    endgenerate

    assign in_invalid = |digit_bad;
`endif

    // Control FSM, working register, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            bin_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            out_q   <= '0;
`ifdef BCD_CHECK_EN
            inv_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        bcd_q   <= in_bcd;
                        bin_q   <= '0;
                        cnt_q   <= CNT_W'(BIN_W);
                        ready_q <= 1'b0;
                        state_q <= SHIFT;
`ifdef BCD_CHECK_EN
                        inv_q   <= in_invalid;
`endif
                    end
                end
                SHIFT: begin
                    bcd_q <= bcd_d;
                    bin_q <= bin_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    // Last of the BIN_W shifts happens on this edge.
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    valid_q <= 1'b1;
`ifdef BCD_CHECK_EN
                    out_q   <= inv_q ? '0 : bin_q;
                    err_q   <= inv_q;
`else
                    out_q   <= bin_q;
`endif
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready      = ready_q;
    assign valid      = valid_q;
    assign out_binary = out_q;
`ifdef BCD_CHECK_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule
